// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter for the data-memory bus.
// A store to TX_ADDR queues a byte into a small FIFO. The transmit FSM
// drains the FIFO and serialises each byte LSB first, starting with a low
// start bit and ending with a high stop bit. A load from STAT_ADDR returns
// {count, overflow, tx_full, busy}. A store to STAT_ADDR clears the sticky
// overflow flag.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data and stop bits (8E1). When it is left undefined the frame
// is 8N1.
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = 32'h1000_0000,
    parameter logic [31:0] STAT_ADDR    = 32'h1000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        tx_full,
    output logic        TXD
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    // Transmit FSM state
    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic [2:0]        bit_q,   bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q,   txd_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q,   par_d;
`endif

    // FIFO state
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // Bus-visible state
    logic              ovf_q,   ovf_d;
    logic [31:0]       rdata_q, rdata_d;

    // Decoded bus strobes and helpers
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              stat_wr;
    logic              stat_rd;
    logic              empty;
    logic              full;
    logic              busy;
    logic              baud_wrap;
    logic [7:0]        head;
    logic [4:0]        cnt_stat;
    logic [31:0]       status;

    // Upper store lanes are not used by this peripheral.
    logic              unused_bits;
    assign unused_bits = ^{byte_enable[3:1], write_data[31:8]};

    assign push_req  = mem_write && (addr == TX_ADDR) && byte_enable[0];
    assign stat_wr   = mem_write && (addr == STAT_ADDR);
    assign stat_rd   = mem_read  && (addr == STAT_ADDR);
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    // A full FIFO still takes a byte when the transmitter frees a slot on the same edge.
    assign push_ok   = push_req && (!full || pop);
    assign busy      = (state_q != S_IDLE) || !empty;
    assign baud_wrap = (baud_q == BAUD_LAST);
    assign head      = fifo_mem[rd_ptr_q];
    assign cnt_stat  = 5'(count_q);
    assign status    = {24'b0, cnt_stat, ovf_q, full, busy};

    assign tx_full   = full;
    assign TXD       = txd_q;
    assign read_data = rdata_q;

    // Next-state logic of the transmit FSM, including the FIFO pop decision
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    bit_d  = '0;
                    // Chain straight into the next start bit so queued frames have no gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level for the next cycle, derived from the next state so TXD is glitch-free
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // FIFO pointer/count update, overflow flag and registered load data
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A drop on the same edge as a clear leaves the flag set.
        if (stat_wr) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        rdata_d = stat_rd ? status : 32'h0;
    end

    // Control registers; async reset abandons any frame and forces the line high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end

    // Datapath registers: shift register, parity bit and FIFO storage need no reset
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= write_data[7:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Stimulus pushes accepted bytes into an expected-frame queue; a serial-line
// monitor decodes each frame from TXD and checks it against the queue head.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] TX_A   = 32'h1000_0000;
    localparam logic [31:0] STAT_A = 32'h1000_0004;
    localparam logic [31:0] BAD_A  = 32'h1000_0008;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR   = 1'b1;
    localparam int NBITS = 11;
`else
    localparam bit PAR   = 1'b0;
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        tx_full;
    logic        TXD;

    uart_tx_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .TX_ADDR     (TX_A),
        .STAT_ADDR   (STAT_A)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .addr       (addr),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .byte_enable(byte_enable),
        .write_data (write_data),
        .read_data  (read_data),
        .tx_full    (tx_full),
        .TXD        (TXD)
    );

    // Reference model state
    logic [7:0] pending[$];
    logic       m_ovf;
    int         starts[$];

    int n_vec;
    int n_mis;
    int cyc;
    int last_wcyc;

    logic        mon_active;
    logic        mon_unexp;
    int          mon_idx;
    logic [7:0]  mon_byte;
    logic [43:0] mon_samples;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [43:0] exp_frame(input logic [7:0] b);
        logic [43:0] f;
        logic        bv;
        f = '1;
        for (int k = 0; k < NBITS; k++) begin
            if (k == 0)                bv = 1'b0;
            else if (k <= 8)           bv = b[k-1];
            else if (PAR && k == 9)    bv = ^b;
            else                       bv = 1'b1;
            for (int s = 0; s < CPB; s++) f[k*CPB+s] = bv;
        end
        return f;
    endfunction

    function automatic logic [31:0] model_status(input logic busy);
        logic [4:0] c;
        c = 5'(pending.size());
        return {24'b0, c, m_ovf, (pending.size() == DEPTH), busy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Serial-line monitor: samples TXD mid-cycle and checks whole frames
    initial begin
        mon_active  = 1'b0;
        mon_unexp   = 1'b0;
        mon_idx     = 0;
        mon_byte    = '0;
        mon_samples = '1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (TXD == 1'b0) begin
                    mon_active  = 1'b1;
                    mon_samples = '1;
                    mon_samples[0] = TXD;
                    mon_idx     = 1;
                    starts.push_back(cyc);
                    if (pending.size() == 0) begin
                        mon_unexp = 1'b1;
                        mon_byte  = '0;
                        n_vec++;
                        n_mis++;
                        $display("FAIL unexpected_frame: start bit at cycle %0d, expected no frame", cyc);
                    end else begin
                        mon_unexp = 1'b0;
                        mon_byte  = pending.pop_front();
                    end
                end
            end else begin
                mon_samples[mon_idx] = TXD;
                mon_idx++;
                if (mon_idx == FRAME_CYC) begin
                    mon_active = 1'b0;
                    if (!mon_unexp) begin
                        n_vec++;
                        if (mon_samples !== exp_frame(mon_byte)) begin
                            n_mis++;
                            $display("FAIL frame_0x%02h: got samples 0x%011h, expected 0x%011h",
                                     mon_byte, mon_samples, exp_frame(mon_byte));
                        end
                    end
                end
            end
        end
    end

    // One-cycle store; caller is positioned just after a rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr        = a;
        write_data  = d;
        byte_enable = be;
        mem_write   = 1'b1;
        @(posedge clk);
        #1;
        mem_write   = 1'b0;
        byte_enable = 4'h0;
        addr        = 32'h0;
        last_wcyc   = cyc;
        if (a == TX_A && be[0]) begin
            if (pending.size() < DEPTH) pending.push_back(d[7:0]);
            else                        m_ovf = 1'b1;
        end else if (a == STAT_A) begin
            m_ovf = 1'b0;
        end
    endtask

    task automatic bus_read(output logic [31:0] d);
        addr     = STAT_A;
        mem_read = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        addr     = 32'h0;
        d        = read_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int i;
        i = 0;
        while ((pending.size() != 0 || mon_active) && i < max_cyc) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (pending.size() != 0 || mon_active) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s_drain: got %0d frames still queued, expected 0", name, pending.size());
            pending.delete();
        end
        idle(4);
    endtask

    logic [31:0] rd;
    int          s0;
    int          nstarts;
    logic [3:0]  be;
    logic [31:0] a;
    int          op;

    initial begin
        n_vec       = 0;
        n_mis       = 0;
        m_ovf       = 1'b0;
        last_wcyc   = 0;
        rst_n       = 1'b0;
        addr        = 32'h0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        byte_enable = 4'h0;
        write_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Reset state
        check("reset_txd", {31'b0, TXD}, 32'h1);
        check("reset_full", {31'b0, tx_full}, 32'h0);
        check("reset_rdata", read_data, 32'h0);

        // Single 0x55 frame and start latency
        s0 = starts.size();
        bus_write(TX_A, 32'h0000_0055, 4'h1);
        wait_drain("t1", FRAME_CYC + 20);
        check("t1_latency", starts[s0], last_wcyc + 1);

        // Back-to-back frames have no gap
        s0 = starts.size();
        bus_write(TX_A, 32'h0000_00A1, 4'h1);
        bus_write(TX_A, 32'h0000_003C, 4'h1);
        wait_drain("t2", 2 * FRAME_CYC + 20);
        check("t2_gap", starts[s0+1] - starts[s0], FRAME_CYC);

        // Overflow while a frame is in flight
        bus_write(TX_A, 32'h0000_005A, 4'h1);
        idle(8);
        for (int i = 0; i < 5; i++) begin
            bus_write(TX_A, 32'($urandom_range(0, 255)), 4'h1);
            check($sformatf("t3_full_%0d", i), {31'b0, tx_full},
                  {31'b0, (pending.size() == DEPTH)});
        end
        bus_read(rd);
        check("t3_status_ovf", rd, model_status(1'b1));
        idle(1);
        check("t3_rdata_next", read_data, 32'h0);
        bus_write(STAT_A, 32'h0, 4'hF);
        bus_read(rd);
        check("t3_status_clr", rd, model_status(1'b1));
        wait_drain("t3", (DEPTH + 2) * FRAME_CYC + 20);

        // Ignored writes: wrong lane and wrong address
        nstarts = starts.size();
        bus_write(TX_A, 32'h0000_0077, 4'b0010);
        bus_write(BAD_A, 32'h0000_0066, 4'hF);
        idle(2 * FRAME_CYC);
        check("t4_no_frame", starts.size() - nstarts, 0);
        check("t4_txd", {31'b0, TXD}, 32'h1);
        bus_read(rd);
        check("t4_status", rd, model_status(1'b0));

        // Parity patterns (also valid 8N1 frames)
        bus_write(TX_A, 32'h0000_0007, 4'h1);
        wait_drain("t6a", FRAME_CYC + 20);
        bus_write(TX_A, 32'h0000_0003, 4'h1);
        wait_drain("t6b", FRAME_CYC + 20);

        // Async reset mid data bit 3
        bus_write(TX_A, 32'h0000_00F0, 4'h1);
        idle(1 + CPB + 3 * CPB + 1);
        #2;
        rst_n = 1'b0;
        pending.delete();
        m_ovf = 1'b0;
        #1;
        check("t5_txd_async", {31'b0, TXD}, 32'h1);
        idle(3);
        rst_n = 1'b1;
        idle(1);
        nstarts = starts.size();
        bus_read(rd);
        check("t5_status", rd, 32'h0);
        idle(2 * FRAME_CYC);
        check("t5_no_frame", starts.size() - nstarts, 0);

        // Randomised bus traffic
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 9));
            be = 4'($urandom_range(0, 15));
            case (op)
                0, 1, 2, 3, 4, 5: a = TX_A;
                6:                a = BAD_A;
                7:                a = STAT_A;
                default:          a = 32'h0;
            endcase
            for (int w = 0; w < 4 * FRAME_CYC && pending.size() >= DEPTH - 1; w++) idle(1);
            if (op == 9) begin
                bus_read(rd);
            end else begin
                bus_write(a, 32'($urandom()), be);
            end
            idle(int'($urandom_range(0, 2 * FRAME_CYC)));
        end
        wait_drain("rand", (DEPTH + 2) * FRAME_CYC + 20);
        bus_read(rd);
        check("final_status", rd, model_status(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected finish before limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
        $fatal(1, "timeout");
    end

endmodule
